// File: rtl/melody_sequencer_pkg.sv
// Shared definitions for the sound blocks: table geometry, sequencer states,
// table entry layout and the sine clkgen maxval for each note of the scale.
package melody_sequencer_pkg;

  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = 5;
  localparam int DW    = 13;
  localparam int EW    = PW + DW;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_PLAY  = 3'd2,
    ST_GAP   = 3'd3,
    ST_END   = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic [PW-1:0] pitch;
    logic [DW-1:0] dur;
  } note_entry_t;

  localparam logic [PW-1:0] NOTE_REST  = 5'd0;
  localparam logic [PW-1:0] NOTE_D     = 5'd27;
  localparam logic [PW-1:0] NOTE_E     = 5'd24;
  localparam logic [PW-1:0] NOTE_FIS   = 5'd21;
  localparam logic [PW-1:0] NOTE_G     = 5'd20;
  localparam logic [PW-1:0] NOTE_A     = 5'd18;
  localparam logic [PW-1:0] NOTE_B     = 5'd16;
  localparam logic [PW-1:0] NOTE_C     = 5'd15;
  localparam logic [PW-1:0] NOTE_DHIGH = 5'd13;

  // A zero-duration entry terminates the song.
  function automatic logic is_end_marker(input note_entry_t e);
    return (e.dur == {DW{1'b0}});
  endfunction

  function automatic logic is_rest(input note_entry_t e);
    return (e.pitch == NOTE_REST);
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Host/tone-datapath side bundle of the melody sequencer: table write port,
// playback control, and the pitch/mute/phase-restart outputs.
interface melody_sequencer_if;
  import melody_sequencer_pkg::*;

  logic          fs_tick;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  note_entry_t   wr_data;
  logic          start;
  logic          stop;
  logic          loop_en;

  logic [PW-1:0] pitch;
  logic          mute;
  logic          note_start;
  logic          busy;
  logic          done;
  logic [AW-1:0] cur_idx;

  modport master (
    output fs_tick, wr_en, wr_addr, wr_data, start, stop, loop_en,
    input  pitch, mute, note_start, busy, done, cur_idx
  );

  modport slave (
    input  fs_tick, wr_en, wr_addr, wr_data, start, stop, loop_en,
    output pitch, mute, note_start, busy, done, cur_idx
  );

endinterface

// File: rtl/melody_sequencer_note_table.sv
// Song table: DEPTH x {pitch, dur} simple dual-port RAM with one write port and a
// registered read port. A same-address write and read in one cycle returns old data.
module melody_sequencer_note_table
  import melody_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  note_entry_t   wr_data,
  input  logic [AW-1:0] rd_addr,
  output note_entry_t   rd_data
);

  note_entry_t mem_q [DEPTH];
  note_entry_t rd_data_q;

  // Contents are deliberately not reset so a loaded song survives a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/melody_sequencer.sv
// Programmable note scheduler: steps through the song table on fs_tick and drives
// the sine clkgen maxval, DAC mute gating and a per-note phase-restart pulse.
module melody_sequencer
  import melody_sequencer_pkg::*;
#(
  parameter int BEAT_DIV  = 2000,
  parameter int GAP_TICKS = 80
) (
  input  logic              clk,
  input  logic              reset,
  melody_sequencer_if.slave bus
);

  localparam int PRW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam int GW  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  localparam logic [PRW-1:0] PRESC_LAST = PRW'(BEAT_DIV - 1);
  localparam logic [GW-1:0]  GAP_LAST   = GW'((GAP_TICKS > 0) ? (GAP_TICKS - 1) : 0);
  localparam logic [AW-1:0]  IDX_LAST   = AW'(DEPTH - 1);
  localparam bit             HAS_GAP    = (GAP_TICKS > 0);

  seq_state_e     state_q, state_d;
  logic [AW-1:0]  cur_idx_q, cur_idx_d;
  logic [PRW-1:0] presc_q, presc_d;
  logic [DW-1:0]  beat_q, beat_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [DW-1:0]  dur_q, dur_d;
  logic [PW-1:0]  pitch_q, pitch_d;
  logic           mute_q, mute_d;
  logic           note_start_q, note_start_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  note_entry_t    rd_entry_s;
  logic [AW-1:0]  rd_addr_s;
  seq_state_e     adv_state_s;
  logic [AW-1:0]  adv_idx_s;

  // The read is issued on the edge that enters FETCH, so the entry is
  // available during FETCH and the note can start on the following edge.
  assign rd_addr_s = cur_idx_d;

  melody_sequencer_note_table u_table (
    .clk     (clk),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (rd_addr_s),
    .rd_data (rd_entry_s)
  );

  // Where to go once a note (and its articulation gap) is finished.
  always_comb begin
    if (cur_idx_q == IDX_LAST) begin
      adv_state_s = ST_END;
      adv_idx_s   = cur_idx_q;
    end else begin
      adv_state_s = ST_FETCH;
      adv_idx_s   = cur_idx_q + AW'(1'b1);
    end
  end

  // Sequencer next-state, counters and output decode.
  always_comb begin
    state_d      = state_q;
    cur_idx_d    = cur_idx_q;
    presc_d      = presc_q;
    beat_d       = beat_q;
    gap_d        = gap_q;
    dur_d        = dur_q;
    pitch_d      = pitch_q;
    mute_d       = mute_q;
    note_start_d = 1'b0;
    done_d       = 1'b0;

    if (bus.stop) begin
      state_d   = ST_IDLE;
      cur_idx_d = '0;
      presc_d   = '0;
      beat_d    = '0;
      gap_d     = '0;
      mute_d    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d   = ST_FETCH;
            cur_idx_d = '0;
          end else begin
            state_d   = ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (is_end_marker(rd_entry_s)) begin
            state_d      = ST_END;
          end else begin
            state_d      = ST_PLAY;
            pitch_d      = rd_entry_s.pitch;
            mute_d       = is_rest(rd_entry_s);
            note_start_d = 1'b1;
            dur_d        = rd_entry_s.dur;
            presc_d      = '0;
            beat_d       = '0;
            gap_d        = '0;
          end
        end
        ST_PLAY: begin
          if (bus.fs_tick) begin
            if (presc_q == PRESC_LAST) begin
              presc_d = '0;
              // Last prescaler wrap of the last beat ends the note.
              if (beat_q == (dur_q - DW'(1'b1))) begin
                beat_d = '0;
                if (HAS_GAP) begin
                  state_d = ST_GAP;
                  mute_d  = 1'b1;
                  gap_d   = '0;
                end else begin
                  state_d   = adv_state_s;
                  cur_idx_d = adv_idx_s;
                end
              end else begin
                beat_d = beat_q + DW'(1'b1);
              end
            end else begin
              presc_d = presc_q + PRW'(1'b1);
            end
          end else begin
            presc_d = presc_q;
          end
        end
        ST_GAP: begin
          if (bus.fs_tick) begin
            if (gap_q == GAP_LAST) begin
              gap_d     = '0;
              state_d   = adv_state_s;
              cur_idx_d = adv_idx_s;
            end else begin
              gap_d     = gap_q + GW'(1'b1);
            end
          end else begin
            gap_d = gap_q;
          end
        end
        ST_END: begin
          if (bus.loop_en) begin
            state_d   = ST_FETCH;
            cur_idx_d = '0;
          end else begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            mute_d    = 1'b1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          cur_idx_d = '0;
          mute_d    = 1'b1;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cur_idx_q    <= '0;
      presc_q      <= '0;
      beat_q       <= '0;
      gap_q        <= '0;
      dur_q        <= '0;
      pitch_q      <= '0;
      mute_q       <= 1'b1;
      note_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_idx_q    <= cur_idx_d;
      presc_q      <= presc_d;
      beat_q       <= beat_d;
      gap_q        <= gap_d;
      dur_q        <= dur_d;
      pitch_q      <= pitch_d;
      mute_q       <= mute_d;
      note_start_q <= note_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.pitch      = pitch_q;
  assign bus.mute       = mute_q;
  assign bus.note_start = note_start_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cur_idx    = cur_idx_q;

endmodule
